// File: rtl/j1b_io_pkg.sv
// Shared constants and helpers for the j1b I/O port block: address decode
// bits, status register layout and the status word builder.
package j1b_io_pkg;

    // Address bits selecting the per-channel data and status registers
    localparam int IO_DATA_BIT = 12;
    localparam int IO_STAT_BIT = 13;

    // Status register bit positions
    localparam int ST_ONE     = 0;
    localparam int ST_RXNE    = 1;
    localparam int ST_TXE     = 2;
    localparam int ST_RXOVF   = 3;
    localparam int ST_TXOVF   = 4;
    localparam int ST_CNT_LSB = 8;

    // Builds a channel status word; the RX count saturates at 255 so a
    // 256-deep FIFO still fits the 8-bit count field.
    function automatic logic [31:0] status_word(
        input logic       rxne,
        input logic       txe,
        input logic       rxovf,
        input logic       txovf,
        input logic [8:0] count
    );
        logic [31:0] word;
        word                     = '0;
        word[ST_ONE]             = 1'b1;
        word[ST_RXNE]            = rxne;
        word[ST_TXE]             = txe;
        word[ST_RXOVF]           = rxovf;
        word[ST_TXOVF]           = txovf;
        word[ST_CNT_LSB +: 8]    = count[8] ? 8'hFF : count[7:0];
        return word;
    endfunction

endpackage

// File: rtl/j1b_byte_fifo.sv
// Byte-wide synchronous FIFO used as the per-channel RX queue. Pushes
// while full and pops while empty are ignored; fullness and emptiness
// are judged on the state at the start of the cycle.
module j1b_byte_fifo
    import j1b_io_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_push,
    input  logic [7:0]    i_din,
    input  logic          i_pop,
    output logic [7:0]    o_dout,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic          w_doPush;
    logic          w_doPop;

    assign o_full   = (r_count == (AW+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_doPush = i_push & ~o_full;
    assign w_doPop  = i_pop & ~o_empty;
    assign o_dout   = r_mem[r_rdPtr];
    assign o_count  = r_count;

    // Storage array; contents need no reset because the count gates reads
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_din;
        end
    end

    // Pointers wrap naturally at DEPTH; the count tracks occupancy
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/j1b_io_ports.sv
// j1b I/O port block: registers the CPU I/O strobes, decodes the captured
// address and serves NCH UART channels, each with an RX FIFO, a one-byte
// TX holding register and clear-on-read overflow flags.
module j1b_io_ports
    import j1b_io_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int RXDEPTH = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_io_rd,
    input  logic               i_io_wr,
    input  logic [15:0]        i_mem_addr,
    input  logic [31:0]        i_dout,
    output logic [31:0]        o_io_din,
    output logic [8*NCH-1:0]   o_tx_data,
    output logic [NCH-1:0]     o_tx_valid,
    input  logic [NCH-1:0]     i_tx_ready,
    input  logic [8*NCH-1:0]   i_rx_data,
    input  logic [NCH-1:0]     i_rx_valid,
    output logic [NCH-1:0]     o_rx_ready
);

    localparam int AW = $clog2(RXDEPTH);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic                   r_io_rd;
    logic                   r_io_wr;
    logic [15:0]            r_io_addr;
    logic [31:0]            r_dout;
    logic [CW-1:0]          w_idx;
    logic                   w_chanOk;
    logic                   w_isData;
    logic                   w_isStat;
    logic [NCH-1:0]         w_sel;
    logic [NCH-1:0][31:0]   w_chanWord;
    logic                   w_unused;

    // Capture the CPU strobes every cycle and the address/data on access
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_io_rd   <= 1'b0;
            r_io_wr   <= 1'b0;
            r_io_addr <= '0;
            r_dout    <= '0;
        end else begin
            r_io_rd <= i_io_rd;
            r_io_wr <= i_io_wr;
            if (i_io_rd | i_io_wr) begin
                r_io_addr <= i_mem_addr;
                r_dout    <= i_dout;
            end
        end
    end

    // Channel index is the word address truncated to the channel count width
    assign w_idx    = (NCH > 1) ? r_io_addr[2 +: CW] : '0;
    assign w_chanOk = (int'(w_idx) < NCH);
    assign w_isData = r_io_addr[IO_DATA_BIT];
    assign w_isStat = r_io_addr[IO_STAT_BIT];
    assign w_unused = ^{r_io_addr, r_dout};

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [7:0]  w_head;
        logic [AW:0] w_count;
        logic        w_full;
        logic        w_empty;
        logic        w_pop;
        logic        w_statRd;
        logic        w_wrHit;
        logic        r_txValid;
        logic [7:0]  r_txData;
        logic        r_txOvf;
        logic        r_rxOvf;
        logic [31:0] w_dataWord;
        logic [31:0] w_statWord;

        assign w_sel[g]  = w_chanOk & (w_idx == CW'(g));
        assign w_pop     = r_io_rd & w_isData & w_sel[g];
        assign w_statRd  = r_io_rd & w_isStat & w_sel[g];
        assign w_wrHit   = r_io_wr & w_isData & w_sel[g];

        j1b_byte_fifo #(.DEPTH(RXDEPTH)) u_rxFifo (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_push  (i_rx_valid[g]),
            .i_din   (i_rx_data[8*g +: 8]),
            .i_pop   (w_pop),
            .o_dout  (w_head),
            .o_count (w_count),
            .o_full  (w_full),
            .o_empty (w_empty)
        );

        // TX holding register: a write is accepted when empty or draining
        // this cycle, otherwise it is dropped and flagged as overflow
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_txValid <= 1'b0;
                r_txData  <= '0;
                r_txOvf   <= 1'b0;
            end else begin
                if (w_wrHit && (!r_txValid || i_tx_ready[g])) begin
                    r_txValid <= 1'b1;
                    r_txData  <= r_dout[7:0];
                end else if (r_txValid && i_tx_ready[g]) begin
                    r_txValid <= 1'b0;
                end
                if (w_wrHit && r_txValid && !i_tx_ready[g]) begin
                    r_txOvf <= 1'b1;
                end else if (w_statRd) begin
                    r_txOvf <= 1'b0;
                end
            end
        end

        // RX overflow is sticky; a new overflow beats a same-cycle clear
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_rxOvf <= 1'b0;
            end else if (i_rx_valid[g] && w_full) begin
                r_rxOvf <= 1'b1;
            end else if (w_statRd) begin
                r_rxOvf <= 1'b0;
            end
        end

        assign w_dataWord = (w_isData && !w_empty) ? {24'd0, w_head} : '0;
        assign w_statWord = w_isStat ? status_word(!w_empty, !r_txValid, r_rxOvf,
                                                   r_txOvf, 9'(w_count))
                                     : '0;
        assign w_chanWord[g]       = w_sel[g] ? (w_dataWord | w_statWord) : '0;
        assign o_tx_data[8*g +: 8] = r_txData;
        assign o_tx_valid[g]       = r_txValid;
        assign o_rx_ready[g]       = ~w_full & ~i_reset;
    end

    // Read data: at most one channel is selected, so OR-merge the channels
    always_comb begin
        o_io_din = '0;
        for (int c = 0; c < NCH; c++) begin
            o_io_din = o_io_din | w_chanWord[c];
        end
    end

endmodule

// File: doc/j1b_io_ports.md
# j1b_io_ports

Parametrised I/O port block for the j1b SoC: registers the CPU's I/O strobes and address, decodes them, and serves NCH byte-wide UART channels. Each channel has an RX FIFO and a one-byte TX holding register. Sticky overflow flags are cleared on read. It sits between the j1 core's io_rd/io_wr/mem_addr/dout/io_din signals and the UART cores, and supersedes the single-channel hard-wired decode.

## Interface
- NCH, 2: number of UART channels, 1..4.
- RXDEPTH, 16: RX FIFO entries per channel; power of two, 2..256.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- io_rd  in  1  CPU I/O read strobe, 1 cycle.
- io_wr  in  1  CPU I/O write strobe, 1 cycle.
- mem_addr  in  16  CPU I/O address.
- dout  in  32  CPU write data.
- io_din  out  32  CPU read data; combinational from registered state.
- tx_data  out  8*NCH  per-channel TX byte; channel c at [8c+7:8c].
- tx_valid  out  NCH  TX holding register full.
- tx_ready  in  NCH  UART accepted the byte this cycle.
- rx_data  in  8*NCH  per-channel received byte.
- rx_valid  in  NCH  one-cycle strobe: byte received.
- rx_ready  out  NCH  FIFO has room; advisory only, the source does not stall.

## Operation
- Capture: each cycle io_rd_ <= io_rd and io_wr_ <= io_wr. When io_rd|io_wr, io_addr_ <= mem_addr and dout_ <= dout. All access decode uses the captured copies.
- Channel index: c = io_addr_[3:2], truncated to clog2(NCH) bits.
  - c >= NCH: the access reads 0 and writes are dropped.
- Data register, io_addr_[12]:
  - Read returns {24'd0, RX FIFO head}, or 0 if empty.
  - Read pops the FIFO when it is non-empty.
  - Write: if tx_valid[c]==0, load dout_[7:0] and set tx_valid[c]. Otherwise drop the byte and set tx_ovf[c].
- Status register, io_addr_[13], read only:
  - bit0 = 1.
  - bit1 = RX FIFO non-empty.
  - bit2 = TX holding register empty.
  - bit3 = rx_ovf.
  - bit4 = tx_ovf.
  - bits[15:8] = RX count, saturating at 255.
  - Other bits = 0.
  - A status read clears both sticky flags of channel c.
- Both address bits set: io_din is the OR of both values. Side effects of both accesses apply.
- TX: tx_valid[c] clears on the cycle tx_valid&tx_ready is high. A CPU write in that same cycle is accepted and loads the new byte (tx_valid stays 1).
- RX push: rx_valid[c] with the FIFO not full pushes rx_data. rx_valid with the FIFO full drops the byte and sets rx_ovf[c].
- rx_ready[c] = !full[c] & !reset.
- Same-cycle push and pop:
  - Empty FIFO: the pop is ignored, the push succeeds, count becomes 1.
  - Full FIFO: the push is rejected, since fullness is evaluated before the pop. rx_ovf is set and the pop proceeds.
- Sticky set versus clear-on-read in the same cycle: set wins.
- FIFO pointers are clog2(RXDEPTH) bits and wrap naturally. The count is clog2(RXDEPTH)+1 bits.

## Timing
- Cycle 0: CPU asserts io_rd. Cycle 1: io_rd_ is high and io_din is valid for the CPU to sample. The pop and flag clear take effect at the end of cycle 1.
- Write latency: tx_valid rises 2 cycles after io_wr (captured at edge 1, loaded at edge 2).
- RX push: visible in status count on the read issued in the cycle after the rx_valid strobe.
- Reset values, held while reset is high:
  - io_rd_, io_wr_ = 0; io_addr_, dout_ = 0.
  - FIFOs empty; all flags 0.
  - tx_valid = 0; tx_data = 0; rx_ready = 0.
  - io_din = 0, because the captured address is 0.
- Reset mid-transfer discards held TX bytes and FIFO contents, with no handshake completion.

## Structure
- Package j1b_io_pkg holds:
  - address-bit constants: IO_DATA_BIT = 12, IO_STAT_BIT = 13.
  - status bit positions: ST_ONE, ST_RXNE, ST_TXE, ST_RXOVF, ST_TXOVF, ST_CNT_LSB.
- Sub-module j1b_byte_fifo (params DEPTH; ports clk, reset, push, din, pop, dout, count, full, empty), instantiated NCH times via generate.
- TX register, flags and decode live in the top.

## Test plan
- Write 0x41 to 0x1000, tx_ready low -> tx_valid[0]=1 at +2 cycles with tx_data[7:0]=0x41. Write 0x42 -> dropped, status 0x2000 bit4=1. Second status read -> bit4=0.
- NCH=2: push 0x55 on ch1. Read 0x2004 -> bits[15:8]=1, bit1=1. Read 0x1004 -> io_din=0x55. Next status -> 0x0005 (TX empty, RX empty).
- RXDEPTH=4: push 5 bytes on ch0 -> rx_ready[0]=0 after the 4th, status 0x0407|0x08 (bit3 set). Reads return bytes 1-4 in order, then 0.
- FIFO full with a pop and rx_valid in the same cycle -> count 3, rx_ovf=1. Empty FIFO with a pop and rx_valid in the same cycle -> count 1, the read returns 0.
- tx_valid&tx_ready coincident with a captured write of 0x43 -> tx_valid stays 1, tx_data=0x43, tx_ovf=0.
- Assert reset with 3 bytes queued and TX full -> next status read gives 0x0005, tx_valid=0.
